// File: rtl/bm_sfifo_param_if.sv
// Handshake/status bundle for bm_sfifo_param.
// err_clr/overflow/underflow exist only when SFIFO_ERR_FLAG_EN is defined.
interface bm_sfifo_param_if #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 4
) ();
    logic [WIDTH-1:0]   data_in;
    logic               read_n;
    logic               write_n;
    logic [WIDTH-1:0]   data_out;
    logic [ADDR_BITS:0] count;
    logic               full;
    logic               empty;
    logic               half;
    logic               almost_full;
    logic               almost_empty;
`ifdef SFIFO_ERR_FLAG_EN
    logic               err_clr;
    logic               overflow;
    logic               underflow;
`endif

    modport master (
        output data_in, read_n, write_n,
`ifdef SFIFO_ERR_FLAG_EN
        output err_clr,
        input  overflow, underflow,
`endif
        input  data_out, count, full, empty, half, almost_full, almost_empty
    );

    modport slave (
        input  data_in, read_n, write_n,
`ifdef SFIFO_ERR_FLAG_EN
        input  err_clr,
        output overflow, underflow,
`endif
        output data_out, count, full, empty, half, almost_full, almost_empty
    );
endinterface

// File: rtl/bm_sfifo_param.sv
// Parametrised synchronous FIFO with registered read data and built-in full/empty protection.
// Define SFIFO_ERR_FLAG_EN to add sticky overflow/underflow flags with err_clr.
module bm_sfifo_param #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int ADDR_BITS     = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input logic             clock,
    input logic             reset,
    bm_sfifo_param_if.slave bus
);
    localparam int CW = ADDR_BITS + 1;
    localparam logic [ADDR_BITS-1:0] LAST_PTR = ADDR_BITS'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] HALF_C  = CW'((DEPTH + 1) / 2);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPT_C = CW'(AEMPTY_THRESH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     data_out_q, data_out_d;
    logic                 full, empty, rd_ok, wr_ok;

    always_comb begin
        full  = (count_q == FULL_C);
        empty = (count_q == '0);
        // No fall-through: an empty FIFO never serves a read, even with a same-cycle write.
        rd_ok = ~bus.read_n & ~empty;
        wr_ok = ~bus.write_n & (~full | ~bus.read_n);

        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;

        if (rd_ok) begin
            data_out_d = mem_q[rd_ptr_q];
            rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is not reset; a write coinciding with reset is discarded.
    always_ff @(posedge clock) begin
        if (wr_ok && !reset) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.half         = (count_q >= HALF_C);
    assign bus.almost_full  = (count_q >= AFULL_C);
    assign bus.almost_empty = (count_q <= AEMPT_C);

`ifdef SFIFO_ERR_FLAG_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new drop in the same cycle as err_clr keeps the flag set.
    always_comb begin
        overflow_d  = (overflow_q  & ~bus.err_clr) | (~bus.write_n & ~wr_ok);
        underflow_d = (underflow_q & ~bus.err_clr) | (~bus.read_n  & ~rd_ok);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_bm_sfifo_param.sv
// Bench for bm_sfifo_param: a DEPTH=16 and a DEPTH=15 instance share one stimulus stream,
// each compared every cycle against a queue-based model plus fixed expectations.
module tb_bm_sfifo_param;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bm_sfifo_param_if #(.WIDTH(8), .ADDR_BITS(4)) b16 ();
    bm_sfifo_param_if #(.WIDTH(8), .ADDR_BITS(4)) b15 ();

    assign b15.data_in = b16.data_in;
    assign b15.read_n  = b16.read_n;
    assign b15.write_n = b16.write_n;
`ifdef SFIFO_ERR_FLAG_EN
    assign b15.err_clr = b16.err_clr;
`endif

    bm_sfifo_param #(.WIDTH(8), .DEPTH(16), .ADDR_BITS(4), .AFULL_THRESH(12), .AEMPTY_THRESH(4))
        u16 (.clock(clock), .reset(reset), .bus(b16));
    bm_sfifo_param #(.WIDTH(8), .DEPTH(15), .ADDR_BITS(4), .AFULL_THRESH(11), .AEMPTY_THRESH(3))
        u15 (.clock(clock), .reset(reset), .bus(b15));

    int depth [2] = '{16, 15};
    int afth  [2] = '{12, 11};
    int aeth  [2] = '{4, 3};
    logic [7:0] mq [2][$];
    logic [7:0] mdout [2];
    logic       movf [2];
    logic       munf [2];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst, rn, wn;
        logic [7:0] d;
        int         cnt;
        logic [7:0] dout;
        logic       emp, ful;
    } vec_t;

    function automatic vec_t mkv(input logic rst, rn, wn, input logic [7:0] d,
                                 input int cnt, input logic [7:0] dout, input logic emp, ful);
        vec_t v;
        v.rst = rst; v.rn = rn; v.wn = wn; v.d = d;
        v.cnt = cnt; v.dout = dout; v.emp = emp; v.ful = ful;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the FIFO is a queue; drops follow the acceptance rules.
    task automatic model_step(input logic rst, rn, wn, clr, input logic [7:0] d);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                mdout[k] = 8'h00;
                movf[k]  = 1'b0;
                munf[k]  = 1'b0;
            end else begin
                int  n;
                logic rok, wok;
                n   = mq[k].size();
                rok = !rn && (n > 0);
                wok = !wn && ((n < depth[k]) || !rn);
                movf[k] = (movf[k] && !clr) || (!wn && !wok);
                munf[k] = (munf[k] && !clr) || (!rn && !rok);
                if (rok) mdout[k] = mq[k].pop_front();
                if (wok) mq[k].push_back(d);
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int n;
            logic [7:0] a_do;
            logic [4:0] a_cnt;
            logic a_f, a_e, a_h, a_af, a_ae, a_ov, a_un;
            n = mq[k].size();
            a_ov = movf[k];
            a_un = munf[k];
            if (k == 0) begin
                a_do = b16.data_out; a_cnt = b16.count; a_f = b16.full; a_e = b16.empty;
                a_h = b16.half; a_af = b16.almost_full; a_ae = b16.almost_empty;
`ifdef SFIFO_ERR_FLAG_EN
                a_ov = b16.overflow; a_un = b16.underflow;
`endif
            end else begin
                a_do = b15.data_out; a_cnt = b15.count; a_f = b15.full; a_e = b15.empty;
                a_h = b15.half; a_af = b15.almost_full; a_ae = b15.almost_empty;
`ifdef SFIFO_ERR_FLAG_EN
                a_ov = b15.overflow; a_un = b15.underflow;
`endif
            end
            chk($sformatf("model u%0d count", depth[k]), a_cnt, n);
            chk($sformatf("model u%0d data_out", depth[k]), a_do, mdout[k]);
            chk($sformatf("model u%0d full", depth[k]), a_f, n == depth[k]);
            chk($sformatf("model u%0d empty", depth[k]), a_e, n == 0);
            chk($sformatf("model u%0d half", depth[k]), a_h, n >= (depth[k] + 1) / 2);
            chk($sformatf("model u%0d almost_full", depth[k]), a_af, n >= afth[k]);
            chk($sformatf("model u%0d almost_empty", depth[k]), a_ae, n <= aeth[k]);
`ifdef SFIFO_ERR_FLAG_EN
            chk($sformatf("model u%0d overflow", depth[k]), a_ov, movf[k]);
            chk($sformatf("model u%0d underflow", depth[k]), a_un, munf[k]);
`endif
        end
    endtask

    task automatic cyc(input logic rst, rn, wn, input logic [7:0] d, input logic clr = 1'b0);
        reset       = rst;
        b16.read_n  = rn;
        b16.write_n = wn;
        b16.data_in = d;
`ifdef SFIFO_ERR_FLAG_EN
        b16.err_clr = clr;
`endif
        model_step(rst, rn, wn, clr, d);
        @(posedge clock);
        #1;
        check_all();
    endtask

    initial begin
        vec_t tbl [9];
        reset = 1'b1; b16.read_n = 1'b1; b16.write_n = 1'b1; b16.data_in = '0;
`ifdef SFIFO_ERR_FLAG_EN
        b16.err_clr = 1'b0;
`endif

        // Short table: basic write/read, rw with data, and rw on empty (no fall-through)
        tbl[0] = mkv(1, 1, 1, 8'h00, 0, 8'h00, 1, 0);
        tbl[1] = mkv(0, 1, 0, 8'hA1, 1, 8'h00, 0, 0);
        tbl[2] = mkv(0, 1, 0, 8'hA2, 2, 8'h00, 0, 0);
        tbl[3] = mkv(0, 0, 0, 8'hA3, 2, 8'hA1, 0, 0);
        tbl[4] = mkv(0, 0, 1, 8'h00, 1, 8'hA2, 0, 0);
        tbl[5] = mkv(0, 0, 1, 8'h00, 0, 8'hA3, 1, 0);
        tbl[6] = mkv(0, 0, 1, 8'h00, 0, 8'hA3, 1, 0);
        tbl[7] = mkv(0, 0, 0, 8'h3C, 1, 8'hA3, 0, 0);
        tbl[8] = mkv(0, 0, 1, 8'h00, 0, 8'h3C, 1, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].rst, tbl[i].rn, tbl[i].wn, tbl[i].d);
            chk($sformatf("vec%0d count", i), b16.count, tbl[i].cnt);
            chk($sformatf("vec%0d data_out", i), b16.data_out, tbl[i].dout);
            chk($sformatf("vec%0d empty", i), b16.empty, tbl[i].emp);
            chk($sformatf("vec%0d full", i), b16.full, tbl[i].ful);
        end

        // Fill to full, threshold edges, dropped 17th write
        cyc(1, 1, 1, 8'h00);
        chk("reset almost_empty", b16.almost_empty, 1'b1);
        chk("reset half", b16.half, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, 0, 8'(i));
            chk($sformatf("fill%0d count", i), b16.count, i);
            chk($sformatf("fill%0d half", i), b16.half, i >= 8);
            chk($sformatf("fill%0d almost_full", i), b16.almost_full, i >= 12);
            chk($sformatf("fill%0d almost_empty", i), b16.almost_empty, i <= 4);
        end
        chk("fill full", b16.full, 1'b1);
        cyc(0, 1, 0, 8'hAA);
        chk("overfill count", b16.count, 16);
`ifdef SFIFO_ERR_FLAG_EN
        chk("overfill overflow", b16.overflow, 1'b1);
`endif
        cyc(0, 1, 1, 8'h00, 1'b1);
`ifdef SFIFO_ERR_FLAG_EN
        chk("err_clr overflow", b16.overflow, 1'b0);
`endif

        // Drain in order, then an extra read holds data_out
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, 8'h00);
            chk($sformatf("drain%0d data_out", i), b16.data_out, i + 1);
        end
        chk("drain empty", b16.empty, 1'b1);
        cyc(0, 0, 1, 8'h00);
        chk("underread data_out", b16.data_out, 8'h10);
`ifdef SFIFO_ERR_FLAG_EN
        chk("underread underflow", b16.underflow, 1'b1);
`endif

        // Full FIFO, simultaneous read+write for 20 cycles
        cyc(0, 1, 1, 8'h00, 1'b1);
        for (int i = 1; i <= 16; i++) cyc(0, 1, 0, 8'(i));
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 8'h55);
            chk($sformatf("rwfull%0d count", i), b16.count, 16);
            chk($sformatf("rwfull%0d data_out", i), b16.data_out, (i < 16) ? i + 1 : 8'h55);
        end

        // DEPTH=15 pointer wrap: 15 in, 7 out, 7 in, 15 out
        cyc(1, 1, 1, 8'h00);
        for (int i = 1; i <= 15; i++) cyc(0, 1, 0, 8'(i));
        chk("wrap15 full", b15.full, 1'b1);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 1, 8'h00);
            chk($sformatf("wrap15 r1_%0d", i), b15.data_out, i + 1);
        end
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 8'(8'h21 + i));
        chk("wrap15 refull", b15.full, 1'b1);
        for (int i = 0; i < 15; i++) begin
            cyc(0, 0, 1, 8'h00);
            chk($sformatf("wrap15 r2_%0d", i), b15.data_out, (i < 8) ? 8 + i : 8'h21 + i - 8);
        end
        chk("wrap15 empty", b15.empty, 1'b1);

        // Reset mid-stream with a write pending
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'(8'h90 + i));
        cyc(0, 0, 1, 8'h00);
        cyc(0, 1, 0, 8'hEE);
        cyc(1, 1, 0, 8'h77);
        chk("midrst count", b16.count, 0);
        chk("midrst empty", b16.empty, 1'b1);
        chk("midrst data_out", b16.data_out, 8'h00);
`ifdef SFIFO_ERR_FLAG_EN
        chk("midrst overflow", b16.overflow, 1'b0);
        chk("midrst underflow", b16.underflow, 1'b0);
`endif

        // Random traffic with alternating write-heavy / read-heavy phases
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 150) % 2 == 0) ? 70 : 30;
            cyc(($urandom_range(0, 399) == 0),
                ($urandom_range(0, 99) >= (100 - wp)),
                ($urandom_range(0, 99) >= wp),
                8'($urandom),
                ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bm_sfifo_param.md
Name: bm_sfifo_param

Overview:
Parametrised synchronous FIFO: successor to the fixed 15x8 benchmark FIFO.
- Width, depth and almost-full/almost-empty thresholds are parameters.
- All DEPTH locations are usable; the occupancy counter is ADDR_BITS+1 wide.
- Full/empty protection is built in: a write when full or a read when empty is dropped with no corruption.
- Standalone microbenchmark; single clock domain; registered read data.

Parameters:
WIDTH, 8, data width in bits
DEPTH, 16, number of entries; any value >= 2 (non-power-of-two allowed)
ADDR_BITS, 4, pointer width; must satisfy 2**ADDR_BITS >= DEPTH
AFULL_THRESH, 12, almost_full asserts when count >= AFULL_THRESH
AEMPTY_THRESH, 4, almost_empty asserts when count <= AEMPTY_THRESH

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
data_in  input  WIDTH  write data
read_n  input  1  read request, active low
write_n  input  1  write request, active low
data_out  output  WIDTH  registered read data
count  output  ADDR_BITS+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
half  output  1  count >= (DEPTH+1)/2 (integer divide)
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
err_clr  input  1  clears sticky error flags (present only with SFIFO_ERR_FLAG_EN)
overflow  output  1  sticky: a write was dropped (present only with SFIFO_ERR_FLAG_EN)
underflow  output  1  sticky: a read was dropped (present only with SFIFO_ERR_FLAG_EN)

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising clock edge; it has priority over all other inputs.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, data_out=0, overflow=0, underflow=0. Memory contents are not reset.
- Status flags (full, empty, half, almost_full, almost_empty) are combinational decodes of the registered count.
  - After reset: empty=1, almost_empty=1, all other flags 0.
- Request qualification, per cycle:
  - rd_ok = ~read_n & (~empty | 0). A read with empty=1 is never accepted, even if a write arrives in the same cycle (no fall-through).
  - wr_ok = ~write_n & (~full | ~read_n). A write with full=1 is accepted only if a read is also requested that cycle (rd_ok is necessarily 1 then).
- On rd_ok:
  - data_out <= mem[rd_ptr].
  - Latency: data appears 1 cycle after the read is sampled.
  - rd_ptr advances; wraps to 0 when at DEPTH-1.
- When no read is accepted: data_out holds its previous value.
- On wr_ok: mem[wr_ptr] <= data_in; wr_ptr advances with the same wrap rule.
- Count update:
  - +1 on wr_ok & ~rd_ok.
  - -1 on rd_ok & ~wr_ok.
  - Unchanged otherwise.
  - count never leaves 0..DEPTH.
- Simultaneous read and write:
  - When full: both are performed; count stays DEPTH; data_out gets the oldest entry.
  - When empty: the write is performed, the read is dropped; count becomes 1; data_out holds.
- Reset asserted mid-stream: the next edge returns the FIFO to the reset state; the same-cycle read/write is discarded.
- Pointer arithmetic is done in ADDR_BITS; wrap is an explicit compare against DEPTH-1, not natural overflow.

Optional Feature:
Macro SFIFO_ERR_FLAG_EN.
- Defined:
  - err_clr, overflow and underflow ports exist.
  - overflow sets on the cycle after any write with write_n=0 and wr_ok=0.
  - underflow sets on the cycle after any read with read_n=0 and rd_ok=0.
  - Both flags are sticky until reset or err_clr=1. err_clr is synchronous.
  - If err_clr and a new error occur in the same cycle, set wins.
- Not defined: those three ports and their logic are absent. Dropped requests are still silently ignored, exactly as above.

Test Plan (defaults WIDTH=8, DEPTH=16):
- Reset, then write 0x01..0x10 over 16 cycles -> count=16, full=1, almost_full=1 from count 12, half=1 from count 8; a 17th write of 0xAA is dropped and count stays 16 (overflow=1 with macro).
- From full, read 16 times -> data_out = 0x01..0x10, each 1 cycle after its read; then empty=1; a further read keeps data_out=0x10 (underflow=1 with macro).
- Full FIFO, simultaneous read+write of 0x55 for 20 cycles -> count stays 16 throughout; the wrap-around order of data_out is preserved, and 0x55 emerges after the 16 original entries.
- Empty FIFO, simultaneous read+write of 0x3C -> count=1, data_out unchanged; next-cycle read -> data_out=0x3C.
- DEPTH=15, ADDR_BITS=4: write 15 entries, read 7, write 7 -> pointers wrap at 14; all 15 remaining entries read back in FIFO order.
- Write 5 entries, assert reset for 1 cycle with write_n=0 -> count=0, empty=1, data_out=0, overflow/underflow=0.
